// File: rtl/mips_pkg.sv
// mips_pkg: MIPS32 opcode constants, instruction field positions and loader FSM states.
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam int OPC_HI = 31, OPC_LO = 26;
   localparam int RS_HI  = 25, RS_LO  = 21;
   localparam int RT_HI  = 20, RT_LO  = 16;
   localparam int RD_HI  = 15, RD_LO  = 11;
   localparam int SH_HI  = 10, SH_LO  = 6;
   localparam int FN_HI  = 5,  FN_LO  = 0;
   localparam int IMM_HI = 15, IMM_LO = 0;
   localparam int ADR_HI = 25, ADR_LO = 0;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/instr_encode_loader_if.sv
// instr_encode_loader_if: decoded-field tuple handshake plus instruction-memory write bus.
interface instr_encode_loader_if #(parameter int ADDR_W = 32);
   logic              in_valid;
   logic              in_ready;
   logic [5:0]        opcode;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       immediate;
   logic [25:0]       address;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              imem_ready;
   modport slave (
      input  in_valid, opcode, rs, rt, rd, shamt, funct, immediate, address, imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
   modport master (
      output in_valid, opcode, rs, rt, rd, shamt, funct, immediate, address, imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/mips_instr_encode.sv
// mips_instr_encode: packs decoded MIPS32 fields into an R, I or J instruction word.
module mips_instr_encode
   import mips_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] immediate,
   input  logic [25:0] address,
   output logic [31:0] word
);
   always_comb begin
      word = '0;
      word[OPC_HI:OPC_LO] = opcode;
      if (opcode == OP_J || opcode == OP_JAL) begin
         word[ADR_HI:ADR_LO] = address;
      end else begin
         word[RS_HI:RS_LO] = rs;
         word[RT_HI:RT_LO] = rt;
         if (opcode == OP_RTYPE) begin
            word[RD_HI:RD_LO] = rd;
            word[SH_HI:SH_LO] = shamt;
            word[FN_HI:FN_LO] = funct;
         end else begin
            word[IMM_HI:IMM_LO] = immediate;
         end
      end
   end
endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes accepted field tuples and writes them to consecutive
// instruction-memory words starting at a programmed base address.
module instr_encode_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]    count,
   output logic                busy,
   output logic                done,
   instr_encode_loader_if.slave bus
);
   state_t            state, nxt;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  remaining;
   logic [31:0]       word;
   logic              accept, retire;
   mips_instr_encode u_enc (
      .opcode    (bus.opcode),
      .rs        (bus.rs),
      .rt        (bus.rt),
      .rd        (bus.rd),
      .shamt     (bus.shamt),
      .funct     (bus.funct),
      .immediate (bus.immediate),
      .address   (bus.address),
      .word      (word)
   );
   // single-entry output register: a new tuple may enter as the held one retires
   assign bus.in_ready = (state == RUN) && (!bus.imem_we || bus.imem_ready);
   assign accept = bus.in_valid && bus.in_ready;
   assign retire = bus.imem_we && bus.imem_ready;
   always_comb begin
      nxt  = state;
      busy = (state == RUN) || (state == DRAIN);
      done = state == DONE;
      case (state)
         IDLE:    if (start) nxt = (count != '0) ? RUN : DONE;
         RUN:     if (accept && remaining == CNT_W'(1)) nxt = DRAIN;
         DRAIN:   if (retire) nxt = DONE;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         addr           <= '0;
         remaining      <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && start) begin
            addr      <= base_addr & ~ADDR_W'(3);
            remaining <= count;
         end
         if (accept) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= addr;
            bus.imem_wdata <= word;
            addr           <= addr + ADDR_W'(4);
            remaining      <= remaining - CNT_W'(1);
         end else if (retire) begin
            bus.imem_we <= 1'b0;
         end
      end
   end
endmodule
